// File: rtl/uart_tx_reader.sv
// UART transmitter that drains a first-word-fall-through TX FIFO one word per frame:
// start bit, DATA_WIDTH data bits LSB first, then a stop period, paced by a 16x baud tick.
module uart_tx_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic [DATA_WIDTH-1:0] i_txff_data,
  input  logic                  i_txff_empty,
  output logic                  o_txff_read,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done_tick
);

  localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;
  logic                  tx_q,       tx_d;
  logic                  read_q,     read_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  // Next-state, counter and output decode; o_tx is precomputed from the next state
  // so the pin is a plain flop output.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
    read_d     = 1'b0;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!i_txff_empty) begin
          shreg_d    = i_txff_data;
          read_d     = 1'b1;
          busy_d     = 1'b1;
          tick_cnt_d = {TW{1'b0}};
          state_d    = S_START;
        end else begin
          busy_d     = 1'b0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_cnt_q == OS_LAST) begin
            tick_cnt_d = {TW{1'b0}};
            bit_cnt_d  = {BW{1'b0}};
            state_d    = S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == OS_LAST) begin
            shreg_d    = shreg_q >> 1;
            tick_cnt_d = {TW{1'b0}};
            if (bit_cnt_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      S_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == SB_LAST) begin
            tick_cnt_d = {TW{1'b0}};
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = {TW{1'b0}};
        bit_cnt_d  = {BW{1'b0}};
        busy_d     = 1'b0;
      end
    endcase

    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line idle-high immediately.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= {TW{1'b0}};
      bit_cnt_q  <= {BW{1'b0}};
      shreg_q    <= {DATA_WIDTH{1'b0}};
      tx_q       <= 1'b1;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx        = tx_q;
  assign o_txff_read = read_q;
  assign o_busy      = busy_q;
  assign o_done_tick = done_q;

endmodule
